// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared types and helpers for the AES job scheduler.
// State encoding, datapath width and the grant one-hot helper.
package aes_sched_pkg;

    localparam int AES_W   = 128;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4,
        ABORT   = 3'd5,
        RESPOND = 3'd6
    } sched_state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first requester after 'last', wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // scan from farthest to nearest so the nearest requester wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin owner of the shared AES-128 decrypt core.
// Latches a job, runs the core, captures plaintext, then releases or aborts.
module aes_job_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int AES_W          = aes_sched_pkg::AES_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [NUM_REQ*AES_W-1:0] REQ_KEY,
    input  logic [NUM_REQ*AES_W-1:0] REQ_MSG,
    output logic [NUM_REQ-1:0]       GNT,
    output logic [NUM_REQ-1:0]       DONE,
    output logic                     ERR,
    output logic [AES_W-1:0]         RESULT,
    output logic                     BUSY,
    output logic [AES_W-1:0]         CORE_KEY,
    output logic [AES_W-1:0]         CORE_MSG,
    output logic                     CORE_START,
    output logic                     CORE_RESET,
    input  logic                     CORE_DONE,
    input  logic [AES_W-1:0]         CORE_MSG_DEC
);
    import aes_sched_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    sched_state_t         state;
    logic [IW-1:0]        last_grant;
    logic [CW-1:0]        cnt;
    logic                 abort_flag;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [AES_W-1:0]     result_q;
    logic [AES_W-1:0]     key_q;
    logic [AES_W-1:0]     msg_q;

    logic                 arb_valid;
    logic [IW-1:0]        arb_idx;

    logic                 start_c;
    logic                 creset_c;
    logic [NUM_REQ-1:0]   done_c;
    logic                 err_c;
    logic                 busy_c;
    logic                 state_ok;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (REQ),
        .last  (last_grant),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // job sequencing: arbitrate, load, run, then capture or abort
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            cnt        <= '0;
            abort_flag <= 1'b0;
            gnt_q      <= '0;
            result_q   <= '0;
            key_q      <= '0;
            msg_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        last_grant <= arb_idx;
                        gnt_q      <= NUM_REQ'(onehot(3'(arb_idx)));
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    key_q      <= REQ_KEY[int'(last_grant)*AES_W +: AES_W];
                    msg_q      <= REQ_MSG[int'(last_grant)*AES_W +: AES_W];
                    cnt        <= '0;
                    abort_flag <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (CORE_DONE) begin
                        state <= CAPTURE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ABORT;
                    end
                end
                CAPTURE: begin
                    result_q <= CORE_MSG_DEC;
                    state    <= RELEASE;
                end
                RELEASE: begin
                    state <= RESPOND;
                end
                ABORT: begin
                    abort_flag <= 1'b1;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    gnt_q      <= '0;
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    gnt_q      <= '0;
                    abort_flag <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // core handshake and requester strobes decoded from the state
    always_comb begin
        start_c  = 1'b0;
        creset_c = 1'b0;
        done_c   = '0;
        err_c    = 1'b0;
        busy_c   = 1'b1;
        state_ok = 1'b1;
        case (state)
            IDLE:    busy_c = 1'b0;
            LOAD:    busy_c = 1'b1;
            RUN:     start_c = 1'b1;
            CAPTURE: busy_c = 1'b1;
            RELEASE: start_c = 1'b1;
            ABORT:   creset_c = 1'b1;
            RESPOND: begin
                done_c = gnt_q;
                err_c  = abort_flag;
            end
            default: begin
                busy_c   = 1'b0;
                state_ok = 1'b0;
            end
        endcase
    end

    assign GNT        = state_ok ? gnt_q : '0;
    assign DONE       = done_c;
    assign ERR        = err_c;
    assign BUSY       = busy_c;
    assign RESULT     = result_q;
    assign CORE_KEY   = key_q;
    assign CORE_MSG   = msg_q;
    assign CORE_START = start_c;
    assign CORE_RESET = creset_c;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler: table vectors, corner sequences and random jobs
// against a behavioural core and a job-level reference model.
module tb_aes_job_scheduler;

    localparam int NR = 2;
    localparam int W  = 128;
    localparam int TO = 48;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] MA = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] KB = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] MB = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] KC = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] MC = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] KD = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] MD = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] KE = 128'hdeadbeef0badf00dcafe1234567890ab;
    localparam logic [127:0] ME = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KF = 128'h55555555aaaaaaaa33333333cccccccc;
    localparam logic [127:0] MF = 128'h0f0f0f0ff0f0f0f01234123443214321;

    logic              CLK;
    logic              RESET;
    logic [NR-1:0]     REQ;
    logic [NR*W-1:0]   REQ_KEY;
    logic [NR*W-1:0]   REQ_MSG;
    logic [NR-1:0]     GNT;
    logic [NR-1:0]     DONE;
    logic              ERR;
    logic [W-1:0]      RESULT;
    logic              BUSY;
    logic [W-1:0]      CORE_KEY;
    logic [W-1:0]      CORE_MSG;
    logic              CORE_START;
    logic              CORE_RESET;
    logic              CORE_DONE;
    logic [W-1:0]      CORE_MSG_DEC;

    aes_job_scheduler #(
        .NUM_REQ        (NR),
        .AES_W          (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .REQ          (REQ),
        .REQ_KEY      (REQ_KEY),
        .REQ_MSG      (REQ_MSG),
        .GNT          (GNT),
        .DONE         (DONE),
        .ERR          (ERR),
        .RESULT       (RESULT),
        .BUSY         (BUSY),
        .CORE_KEY     (CORE_KEY),
        .CORE_MSG     (CORE_MSG),
        .CORE_START   (CORE_START),
        .CORE_RESET   (CORE_RESET),
        .CORE_DONE    (CORE_DONE),
        .CORE_MSG_DEC (CORE_MSG_DEC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // stand-in for the decryptor: real FIPS-197 vector, arbitrary mix otherwise
    function automatic logic [127:0] dec(input logic [127:0] k,
                                         input logic [127:0] m);
        if (k == FK && m == FC) return FP;
        return k ^ {m[63:0], m[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0ff00ff0_96969696;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] p, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (p[(last + k) % NR]) return (last + k) % NR;
        end
        return 0;
    endfunction

    // behavioural core: halted -> running (START level) -> finished;
    // a fresh START rising edge while finished returns it to halted
    int core_lat  = 10;
    bit core_hang = 1'b0;
    int core_cnt  = 0;
    bit core_run  = 1'b0;
    bit core_fin  = 1'b0;
    bit start_d   = 1'b0;

    always @(posedge CLK) begin
        start_d <= CORE_START;
        if (!RESET || CORE_RESET) begin
            core_run <= 1'b0;
            core_fin <= 1'b0;
        end else if (core_fin) begin
            if (CORE_START && !start_d) core_fin <= 1'b0;
        end else if (core_run) begin
            if (!core_hang && core_cnt >= core_lat - 1) begin
                core_run <= 1'b0;
                core_fin <= 1'b1;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end else if (CORE_START) begin
            core_run <= 1'b1;
            core_cnt <= 1;
        end
    end

    assign CORE_DONE    = core_fin;
    assign CORE_MSG_DEC = core_fin ? dec(CORE_KEY, CORE_MSG) : '0;

    typedef struct {
        int           cyc;
        logic [1:0]   done;
        logic [1:0]   gnt;
        logic         err;
        logic [127:0] result;
        logic [127:0] key;
        logic [127:0] msg;
        int           st_cyc;
        int           rises;
        int           resets;
        int           rst_cyc;
        int           last_hi;
    } ev_t;

    ev_t evq[$];
    int  cyc     = 0;
    int  rises   = 0;
    int  resets  = 0;
    int  st_cyc  = 0;
    int  rst_cyc = 0;
    int  hi_len  = 0;
    int  last_hi = 0;
    int  inv_bad = 0;
    bit  prev_st = 1'b0;

    // observe each cycle mid-period and log one record per DONE pulse
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET) begin
                rises   = 0;
                resets  = 0;
                hi_len  = 0;
                prev_st = 1'b0;
            end else begin
                if (CORE_START && !prev_st) begin
                    rises++;
                    if (rises == 1) st_cyc = cyc;
                end
                if (CORE_START) hi_len++;
                else if (prev_st) begin
                    last_hi = hi_len;
                    hi_len  = 0;
                end
                prev_st = CORE_START;
                if (CORE_RESET) begin
                    resets++;
                    rst_cyc = cyc;
                end
                if (CORE_START && CORE_RESET) inv_bad++;
                if (DONE != '0) begin
                    ev_t ne;
                    ne.cyc     = cyc;
                    ne.done    = DONE;
                    ne.gnt     = GNT;
                    ne.err     = ERR;
                    ne.result  = RESULT;
                    ne.key     = CORE_KEY;
                    ne.msg     = CORE_MSG;
                    ne.st_cyc  = st_cyc;
                    ne.rises   = rises;
                    ne.resets  = resets;
                    ne.rst_cyc = rst_cyc;
                    ne.last_hi = last_hi;
                    evq.push_back(ne);
                    rises  = 0;
                    resets = 0;
                end
            end
        end
    end

    task automatic wait_ev(output ev_t e, output bit got);
        got = 1'b0;
        e   = '{default: 0};
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            #1;
            if (evq.size() > 0) begin
                e   = evq.pop_front();
                got = 1'b1;
            end
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            #1;
            if (CORE_START) got = 1'b1;
        end
    endtask

    typedef struct {
        logic [1:0]   req;
        logic [127:0] key0;
        logic [127:0] msg0;
        logic [127:0] key1;
        logic [127:0] msg1;
        int           lat;
        bit           hang;
        logic [1:0]   exp_done;
        bit           exp_err;
        logic [127:0] exp_res;
        logic [127:0] exp_key;
        int           exp_gap;
        int           exp_rst;
        int           exp_rises;
        int           exp_hi;
    } vec_t;

    initial begin
        vec_t         tv[6];
        ev_t          e;
        bit           got;
        int           mlast;
        int           w;
        int           lat;
        bit           experr;
        logic [127:0] mres;
        logic [127:0] expres;
        logic [1:0]   oh;
        logic [127:0] ck[2];
        logic [127:0] cm[2];
        logic [127:0] pk[2];
        logic [127:0] pm[2];
        logic [1:0]   pend;

        tv[0] = '{req: 2'b01, key0: FK, msg0: FC, key1: '0, msg1: '0,
                  lat: 10, hang: 0, exp_done: 2'b01, exp_err: 0,
                  exp_res: FP, exp_key: FK, exp_gap: 13, exp_rst: 0,
                  exp_rises: 2, exp_hi: 1};
        tv[1] = '{req: 2'b10, key0: FK, msg0: FC, key1: KA, msg1: MA,
                  lat: 5, hang: 0, exp_done: 2'b10, exp_err: 0,
                  exp_res: dec(KA, MA), exp_key: KA, exp_gap: 8, exp_rst: 0,
                  exp_rises: 2, exp_hi: 1};
        tv[2] = '{req: 2'b11, key0: KB, msg0: MB, key1: KC, msg1: MC,
                  lat: 7, hang: 0, exp_done: 2'b01, exp_err: 0,
                  exp_res: dec(KB, MB), exp_key: KB, exp_gap: 10, exp_rst: 0,
                  exp_rises: 2, exp_hi: 1};
        tv[3] = '{req: 2'b01, key0: KD, msg0: MD, key1: KC, msg1: MC,
                  lat: 0, hang: 1, exp_done: 2'b01, exp_err: 1,
                  exp_res: dec(KB, MB), exp_key: KD, exp_gap: TO + 1,
                  exp_rst: 1, exp_rises: 1, exp_hi: TO};
        tv[4] = '{req: 2'b10, key0: KD, msg0: MD, key1: KE, msg1: ME,
                  lat: TO - 1, hang: 0, exp_done: 2'b10, exp_err: 0,
                  exp_res: dec(KE, ME), exp_key: KE, exp_gap: TO + 2,
                  exp_rst: 0, exp_rises: 2, exp_hi: 1};
        tv[5] = '{req: 2'b10, key0: KD, msg0: MD, key1: KF, msg1: MF,
                  lat: TO, hang: 0, exp_done: 2'b10, exp_err: 1,
                  exp_res: dec(KE, ME), exp_key: KF, exp_gap: TO + 1,
                  exp_rst: 1, exp_rises: 1, exp_hi: TO};

        RESET   = 1'b0;
        REQ     = '0;
        REQ_KEY = '0;
        REQ_MSG = '0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ctrl", {GNT, DONE, ERR, BUSY, CORE_START, CORE_RESET}, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_core_in", CORE_KEY | CORE_MSG, 0);
        RESET = 1'b1;

        for (int i = 0; i < 6; i++) begin
            REQ_KEY   = {tv[i].key1, tv[i].key0};
            REQ_MSG   = {tv[i].msg1, tv[i].msg0};
            core_lat  = tv[i].lat;
            core_hang = tv[i].hang;
            REQ       = tv[i].req;
            wait_ev(e, got);
            REQ       = '0;
            core_hang = 1'b0;
            chk($sformatf("v%0d_seen", i), got, 1);
            chk($sformatf("v%0d_done", i), e.done, tv[i].exp_done);
            chk($sformatf("v%0d_gnt", i), e.gnt, tv[i].exp_done);
            chk($sformatf("v%0d_err", i), e.err, tv[i].exp_err);
            chk($sformatf("v%0d_result", i), e.result, tv[i].exp_res);
            chk($sformatf("v%0d_core_key", i), e.key, tv[i].exp_key);
            chk($sformatf("v%0d_latency", i), e.cyc - e.st_cyc, tv[i].exp_gap);
            chk($sformatf("v%0d_core_resets", i), e.resets, tv[i].exp_rst);
            chk($sformatf("v%0d_start_rises", i), e.rises, tv[i].exp_rises);
            chk($sformatf("v%0d_last_start_len", i), e.last_hi, tv[i].exp_hi);
            if (tv[i].exp_err) begin
                chk($sformatf("v%0d_abort_at", i), e.rst_cyc - e.st_cyc, TO);
            end
        end
        mlast = 1;
        mres  = dec(KE, ME);

        ck[0] = KA; cm[0] = MA; ck[1] = KB; cm[1] = MB;
        REQ_KEY  = {KB, KA};
        REQ_MSG  = {MB, MA};
        core_lat = 40;
        REQ      = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_ev(e, got);
            w     = rr_pick(2'b11, mlast);
            mlast = w;
            oh    = '0;
            oh[w] = 1'b1;
            mres  = dec(ck[w], cm[w]);
            chk($sformatf("cont%0d_seen", j), got, 1);
            chk($sformatf("cont%0d_done", j), e.done, oh);
            chk($sformatf("cont%0d_latency", j), e.cyc - e.st_cyc, 43);
            chk($sformatf("cont%0d_result", j), e.result, mres);
        end
        REQ = '0;

        REQ_KEY[127:0] = KC;
        REQ_MSG[127:0] = MC;
        core_lat       = 20;
        REQ            = 2'b01;
        wait_start(got);
        chk("chg_started", got, 1);
        repeat (2) @(negedge CLK);
        #1;
        REQ_MSG[127:0] = MD;
        @(negedge CLK);
        #1;
        chk("chg_core_msg_run", CORE_MSG, MC);
        wait_ev(e, got);
        REQ   = '0;
        mlast = 0;
        mres  = dec(KC, MC);
        chk("chg_done", e.done, 2'b01);
        chk("chg_core_msg", e.msg, MC);
        chk("chg_result", e.result, mres);

        REQ_KEY[255:128] = KD;
        REQ_MSG[255:128] = ME;
        core_lat         = 15;
        REQ              = 2'b10;
        wait_start(got);
        repeat (3) @(negedge CLK);
        #1;
        REQ = '0;
        wait_ev(e, got);
        mlast = 1;
        mres  = dec(KD, ME);
        chk("drop_seen", got, 1);
        chk("drop_done", e.done, 2'b10);
        chk("drop_err", e.err, 0);
        chk("drop_result", e.result, mres);

        REQ_KEY[127:0] = KE;
        REQ_MSG[127:0] = MF;
        core_lat       = 30;
        REQ            = 2'b01;
        wait_start(got);
        repeat (4) @(negedge CLK);
        #1;
        RESET = 1'b0;
        REQ   = '0;
        @(negedge CLK);
        #1;
        chk("mid_rst_ctrl", {GNT, DONE, ERR, BUSY, CORE_START, CORE_RESET}, 0);
        chk("mid_rst_data", RESULT | CORE_KEY | CORE_MSG, 0);
        RESET = 1'b1;
        repeat (60) @(negedge CLK);
        #1;
        chk("mid_rst_no_done", evq.size(), 0);
        REQ_KEY[255:128] = KF;
        REQ_MSG[255:128] = MA;
        core_lat         = 12;
        REQ              = 2'b10;
        wait_ev(e, got);
        REQ   = '0;
        mlast = 1;
        mres  = dec(KF, MA);
        chk("post_rst_done", e.done, 2'b10);
        chk("post_rst_result", e.result, mres);
        chk("post_rst_latency", e.cyc - e.st_cyc, 15);

        pend = '0;
        pk[0] = '0; pk[1] = '0; pm[0] = '0; pm[1] = '0;
        for (int j = 0; j < 40; j++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    pk[r]   = rnd128();
                    pm[r]   = rnd128();
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1;
                pk[0]   = rnd128();
                pm[0]   = rnd128();
            end
            REQ_KEY  = {pk[1], pk[0]};
            REQ_MSG  = {pm[1], pm[0]};
            lat      = int'($urandom_range(2, TO + 4));
            core_lat = lat;
            REQ      = pend;
            w        = rr_pick(pend, mlast);
            mlast    = w;
            experr   = (lat >= TO);
            expres   = experr ? mres : dec(pk[w], pm[w]);
            mres     = expres;
            oh       = '0;
            oh[w]    = 1'b1;
            wait_ev(e, got);
            pend[w]  = 1'b0;
            REQ      = pend;
            chk($sformatf("rnd%0d_done", j), e.done, oh);
            chk($sformatf("rnd%0d_err", j), e.err, experr);
            chk($sformatf("rnd%0d_result", j), e.result, expres);
            chk($sformatf("rnd%0d_latency", j), e.cyc - e.st_cyc,
                experr ? TO + 1 : lat + 3);
        end
        REQ = '0;
        repeat (5) @(negedge CLK);

        chk("start_reset_overlap", inv_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares the single AES-128 decryption core between NUM_REQ requesters, e.g. the NIOS Avalon-MM slave path and a DMA engine.
- Arbitrates round-robin and latches the winner's key and ciphertext into the core's input registers.
- Drives the core's level START handshake, captures the plaintext on DONE, and then releases the core back to its idle state.
- A watchdog aborts and resets a core that never finishes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AES_W, 128, key/data width in bits.
- TIMEOUT_CYCLES, 1024, RUN cycles allowed before abort (must be > core worst-case latency).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester job request; level, held until that requester's DONE.
- REQ_KEY  in  NUM_REQ*AES_W  flattened keys; requester i occupies bits [i*AES_W +: AES_W].
- REQ_MSG  in  NUM_REQ*AES_W  flattened ciphertexts, same packing.
- GNT  out  NUM_REQ  one-hot; owner of the current job, held from LOAD through RESPOND.
- DONE  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- ERR  out  1  high together with DONE when the job was aborted by timeout.
- RESULT  out  AES_W  plaintext of the last completed job; held until the next CAPTURE.
- BUSY  out  1  high in every state except IDLE.
- CORE_KEY  out  AES_W  registered key to the core.
- CORE_MSG  out  AES_W  registered ciphertext to the core.
- CORE_START  out  1  core START (level).
- CORE_RESET  out  1  active-high core reset, one-cycle pulse.
- CORE_DONE  in  1  core DONE; level, held while the core sits in its finished state.
- CORE_MSG_DEC  in  AES_W  core plaintext output.

Behaviour:
- Reset (RESET==0 at posedge):
  - state=IDLE; GNT, DONE, ERR, BUSY, CORE_START, CORE_RESET = 0; RESULT, CORE_KEY, CORE_MSG = 0.
  - Timeout counter = 0; last_grant = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-job aborts silently: no DONE, no CORE_RESET.
- IDLE:
  - If |REQ, pick the first requesting index after last_grant, searching modulo NUM_REQ.
  - Next state LOAD; last_grant <= winner.
- LOAD, one cycle:
  - CORE_KEY <= REQ_KEY[winner]; CORE_MSG <= REQ_MSG[winner]; GNT <= onehot(winner).
  - Counter cleared. Next state RUN.
- RUN:
  - CORE_START=1 and counter increments each cycle.
  - CORE_DONE==1 -> CAPTURE; this takes priority over timeout in the same cycle.
  - Otherwise counter == TIMEOUT_CYCLES-1 -> ABORT.
- CAPTURE, one cycle:
  - RESULT <= CORE_MSG_DEC; CORE_START=0. Next state RELEASE.
- RELEASE, one cycle:
  - CORE_START=1 single pulse; this moves the core from finished back to halted.
  - Next state RESPOND, which drives CORE_START=0, so the core is not restarted.
- ABORT, one cycle:
  - CORE_RESET=1; CORE_START=0; RESULT unchanged. Next state RESPOND with ERR set.
- RESPOND, one cycle:
  - DONE[owner]=1 and ERR=abort_flag.
  - GNT clears at the end of the cycle. Next state IDLE.
- Latency, uncontended: REQ seen in IDLE at cycle 0 -> CORE_START at cycle 2 -> DONE 3 cycles after CORE_DONE is first sampled.
- Requester rules:
  - REQ_KEY/REQ_MSG are sampled only in LOAD; later changes are ignored.
  - REQ dropped mid-job: the job still completes and DONE still pulses.
  - REQ still high in the cycle after DONE counts as a new job, arbitrated with the owner now lowest priority.
- CORE_START is never high in two consecutive states across a CAPTURE boundary; CORE_START and CORE_RESET are never high together.
- Unused/illegal state encodings go to IDLE with all outputs low.

Decomposition:
- Package aes_sched_pkg:
  - sched_state_t enum {IDLE, LOAD, RUN, CAPTURE, RELEASE, ABORT, RESPOND}.
  - AES_W localparam.
  - Function onehot(idx).
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], last[$clog2(N)]. Outputs: valid, idx.
  - Purely combinational; instantiated once.
- Everything else lives in the top FSM.

Test Plan:
- Single job, FIPS-197 vector:
  - REQ[0]=1, key 000102030405060708090a0b0c0d0e0f, msg 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: RESULT = 00112233445566778899aabbccddeeff, DONE=01, ERR=0, CORE_START pulsed exactly once in RELEASE.
- Contention:
  - REQ=11 held continuously, behavioral core latency 40.
  - Required: grants alternate 01,10,01,10; each DONE is 43 cycles after its CORE_START rise.
- Timeout:
  - Core never raises DONE, TIMEOUT_CYCLES=16.
  - Required: CORE_RESET pulses exactly 16 cycles after the first RUN cycle, then DONE=01 with ERR=1, RESULT unchanged.
- DONE/timeout collision:
  - CORE_DONE arrives on the counter's final cycle.
  - Required: CAPTURE path taken, ERR=0, no CORE_RESET.
- Reset mid-RUN:
  - RESET low for 1 cycle during RUN.
  - Required: all outputs 0 next cycle, no DONE; a subsequent REQ[1]-only job still completes correctly.
- Input change after LOAD:
  - Alter REQ_MSG[0] during RUN.
  - Required: CORE_MSG and RESULT reflect the value latched in LOAD.
